instruction_fetch_unit: RTL

//  Upstream fetch stage for the CPU control unit. Reads a 16-bit instruction

---
 rtl/instruction_fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: assembles a 16-bit instruction from two byte reads (low byte first)
// and holds it under a valid/ready handshake until the decode stage takes it.
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Fetch_En,
    input  logic              Branch_En,
    input  logic [ADDR_W-1:0] Branch_Target,
    input  logic [7:0]        Mem_Data,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic              Mem_CS,
    output logic              Mem_WR,
    output logic [15:0]       Instr_Out,
    output logic [5:0]        Instr_Opcode,
    output logic [ADDR_W-1:0] Instr_PC,
    output logic              Instr_Valid,
    input  logic              Instr_Ready,
    output logic [ADDR_W-1:0] PC_Out,
    output logic [1:0]        Fetch_State
);

    // Handshake: a word transfers on any cycle where Instr_Valid and Instr_Ready
    // are both 1; while Instr_Valid is 1, Instr_Out and Instr_PC do not change.
    typedef enum logic [1:0] {
        S_REQ_L = 2'd0,
        S_REQ_H = 2'd1,
        S_CAP_H = 2'd2,
        S_VALID = 2'd3
    } fetch_state_t;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instrOut;
    logic [ADDR_W-1:0] instrPc;
    logic              instrValid;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_REQ_L;
            pc         <= RESET_PC;
            instrOut   <= '0;
            instrPc    <= '0;
            instrValid <= 1'b0;
        end else if (Branch_En) begin
            // Redirect drops any partially assembled word; a word sitting in
            // S_VALID with Instr_Ready high has already been consumed this cycle.
            state      <= S_REQ_L;
            pc         <= Branch_Target;
            instrValid <= 1'b0;
        end else begin
            case (state)
                S_REQ_L: begin
                    if (Fetch_En) begin
                        instrPc <= pc;
                        pc      <= pc + ADDR_W'(1);
                        state   <= S_REQ_H;
                    end
                end
                S_REQ_H: begin
                    instrOut[7:0] <= Mem_Data;
                    pc            <= pc + ADDR_W'(1);
                    state         <= S_CAP_H;
                end
                S_CAP_H: begin
                    instrOut[15:8] <= Mem_Data;
                    instrValid     <= 1'b1;
                    state          <= S_VALID;
                end
                S_VALID: begin
                    if (Instr_Ready) begin
                        instrValid <= 1'b0;
                        state      <= S_REQ_L;
                    end
                end
                default: state <= S_REQ_L;
            endcase
        end
    end

    // Chip select is decoded from the current state and inputs so that reset
    // and a redirect suppress the access in the same cycle they are seen.
    always_comb begin
        Mem_CS = 1'b1;
        if (!Reset && !Branch_En) begin
            case (state)
                S_REQ_L: Mem_CS = !Fetch_En;
                S_REQ_H: Mem_CS = 1'b0;
                default: Mem_CS = 1'b1;
            endcase
        end
    end

    assign Mem_Address  = pc;
    assign Mem_WR       = 1'b0;
    assign Instr_Out    = instrOut;
    assign Instr_Opcode = instrOut[15:10];
    assign Instr_PC     = instrPc;
    assign Instr_Valid  = instrValid;
    assign PC_Out       = pc;
    assign Fetch_State  = state;

endmodule
